// File: rtl/keypad_debounce.sv
// Keypad scan debouncer: per-window press classification, debounce FSM, event latch.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat events while a key is held.
module keypad_debounce #(
    parameter int WIN_LEN      = 4,
    parameter int DB_WINDOWS   = 3,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press,
    input  logic [3:0] data,
    input  logic       key_ack,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_int,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [7:0] WLAST = 8'(WIN_LEN - 1);
    localparam logic [3:0] DBN   = 4'(DB_WINDOWS);

    state_t     state, state_n;
    logic [7:0] wcnt;
    logic       last;
    logic       samp_v, conf;
    logic [3:0] samp;
    logic       win_v, win_conf, win_key;
    logic [3:0] win_code;
    logic [3:0] cnt, cnt_n, cnt_inc;
    logic [3:0] cand, cand_n;
    logic       ev_db, ev;

    assign last    = (wcnt == WLAST);
    assign cnt_inc = cnt + 4'd1;

    // Window view including this cycle's strobe, so the final cycle counts too.
    always_comb begin
        win_v    = samp_v;
        win_code = samp;
        win_conf = conf;
        if (press) begin
            if (!samp_v) begin
                win_v    = 1'b1;
                win_code = data;
            end else if (data != samp) begin
                win_conf = 1'b1;
            end
        end
        win_key = win_v && !win_conf;
    end

    always_ff @(posedge clk) begin
        if (rst || last) begin
            wcnt   <= '0;
            samp_v <= 1'b0;
            samp   <= '0;
            conf   <= 1'b0;
        end else begin
            wcnt   <= wcnt + 8'd1;
            samp_v <= win_v;
            samp   <= win_code;
            conf   <= win_conf;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        ev_db   = 1'b0;
        if (last) begin
            unique case (state)
                IDLE: begin
                    if (win_key) begin
                        state_n = PRESS_DB;
                        cand_n  = win_code;
                        cnt_n   = 4'd1;
                    end
                end
                PRESS_DB: begin
                    if (!win_key) begin
                        state_n = IDLE;
                    end else if (win_code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DBN) begin
                            state_n = HELD;
                            ev_db   = 1'b1;
                        end
                    end else begin
                        cand_n = win_code;
                        cnt_n  = 4'd1;
                    end
                end
                HELD: begin
                    if (!win_key) begin
                        state_n = RELEASE_DB;
                        cnt_n   = 4'd1;
                    end
                end
                RELEASE_DB: begin
                    if (win_key) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DBN) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [7:0] RD = 8'(REPEAT_DELAY);
    localparam logic [7:0] RR = 8'(REPEAT_RATE);

    logic [7:0] rcnt, rcnt_inc;
    logic       rptd, held_key, ev_rep;

    assign rcnt_inc = rcnt + 8'd1;
    assign held_key = last && (state == HELD) && win_key;
    assign ev_rep   = held_key && (rcnt_inc == (rptd ? RR : RD));
    assign ev       = ev_db | ev_rep;

    always_ff @(posedge clk) begin
        if (rst || ev_db) begin
            rcnt <= '0;
            rptd <= 1'b0;
        end else if (ev_rep) begin
            rcnt <= '0;
            rptd <= 1'b1;
        end else if (held_key) begin
            rcnt <= rcnt_inc;
        end
    end
`else
    assign ev = ev_db;
`endif

    // An ack in the same cycle frees the slot, so the new event still loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_int   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            key_int <= 1'b0;
            if (ev) begin
                if (!key_valid || key_ack) begin
                    key_code  <= cand;
                    key_valid <= 1'b1;
                    key_int   <= 1'b1;
                    overrun   <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: directed scenarios plus random windows vs a window-level model.
module tb_keypad_debounce;

    localparam int WIN = 4;
    localparam int DB  = 3;
    localparam int RD  = 32;
    localparam int RR  = 8;

    logic       clk, rst, press, key_ack;
    logic [3:0] data;
    logic [3:0] key_code;
    logic       key_valid, key_int, overrun;

    keypad_debounce #(
        .WIN_LEN(WIN), .DB_WINDOWS(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .press(press), .data(data),
        .key_ack(key_ack), .key_code(key_code), .key_valid(key_valid),
        .key_int(key_int), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int nint   = 0;

    int         mpos;
    logic [3:0] wq[$];
    bit         m_pressed;
    logic [3:0] m_code;
    int         m_run, m_none, m_hcnt, m_target;
    logic [3:0] e_code;
    bit         e_valid, e_int, e_ov;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mpos = 0; wq.delete(); m_pressed = 0; m_code = 0;
        m_run = 0; m_none = 0; m_hcnt = 0; m_target = RD;
        e_code = 0; e_valid = 0; e_int = 0; e_ov = 0;
    endtask

    // Classifies each completed window from its list of strobed codes.
    task automatic model_step(input bit p, input logic [3:0] d, input bit a);
        bit         ev, key;
        logic [3:0] c;
        ev = 0;
        if (p) wq.push_back(d);
        if (mpos == WIN - 1) begin
            key = (wq.size() > 0);
            c = key ? wq[0] : 4'd0;
            foreach (wq[i]) if (wq[i] != c) key = 0;
            if (!m_pressed) begin
                if (key) begin
                    if (m_run > 0 && c == m_code) m_run++;
                    else begin m_code = c; m_run = 1; end
                    if (m_run == DB) begin
                        m_pressed = 1; m_none = 0; ev = 1;
                        m_hcnt = 0; m_target = RD;
                    end
                end else m_run = 0;
            end else begin
                if (!key) begin
                    m_none++;
                    if (m_none == DB) begin m_pressed = 0; m_run = 0; end
                end else if (m_none > 0) begin
                    m_none = 0;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_hcnt++;
                    if (m_hcnt == m_target) begin ev = 1; m_target += RR; end
`endif
                end
            end
            wq.delete();
            mpos = 0;
        end else mpos++;
        e_int = 0;
        if (ev) begin
            if (!e_valid || a) begin
                e_code = m_code; e_valid = 1; e_int = 1; e_ov = 0;
            end else e_ov = 1;
        end else if (a) begin
            e_valid = 0; e_ov = 0;
        end
    endtask

    task automatic cyc(input bit p, input logic [3:0] d, input bit a);
        @(negedge clk);
        chk("key_int", 32'(key_int), 32'(e_int));
        chk("key_valid", 32'(key_valid), 32'(e_valid));
        chk("key_code", 32'(key_code), 32'(e_code));
        chk("overrun", 32'(overrun), 32'(e_ov));
        if (key_int === 1'b1) nint++;
        press   = p;
        data    = p ? d : 4'($urandom);
        key_ack = a;
        model_step(p, d, a);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1; press = 0; key_ack = 0;
        repeat (n) @(negedge clk);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_int", 32'(key_int), 0);
        chk("rst_ov", 32'(overrun), 0);
        rst = 0;
        model_reset();
        model_step(0, 0, 0);
    endtask

    task automatic win(input bit p, input logic [3:0] d, input bit a);
        for (int c = 0; c < WIN; c++) cyc(p && c == 0, d, a && c == 0);
    endtask

    task automatic win_conf(input logic [3:0] d1, input logic [3:0] d2);
        for (int c = 0; c < WIN; c++) cyc(c == 0 || c == 2, c == 0 ? d1 : d2, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) win(0, 0, 0);
    endtask

    task automatic rwin(input int kind, input logic [3:0] d);
        int pick;
        pick = $urandom_range(0, WIN - 1);
        for (int c = 0; c < WIN; c++) begin
            bit a;
            a = ($urandom_range(0, 7) == 0);
            if (kind == 1) cyc(c == pick || $urandom_range(0, 1) == 1, d, a);
            else if (kind == 2) cyc(c == 0 || c == WIN - 1, c == 0 ? d : d ^ 4'd1, a);
            else cyc(0, 0, a);
        end
    endtask

    initial begin
        rst = 1; press = 0; data = 0; key_ack = 0;
        model_reset();
        do_reset(2);

        nint = 0;
        win(1, 5, 0); win(1, 5, 0); win(1, 5, 0);
        cyc(0, 0, 0);
        chk("clean_nint", 32'(nint), 1);
        chk("clean_code", 32'(key_code), 5);
        chk("clean_valid", 32'(key_valid), 1);
        cyc(0, 0, 1);
        idle(4);

        nint = 0;
        win(1, 5, 0); win(1, 5, 0); win(0, 0, 0);
        win(1, 5, 0); win(1, 5, 0);
        chk("bounce_early", 32'(nint), 0);
        win(1, 5, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("bounce_nint", 32'(nint), 1);
        cyc(0, 0, 1);
        idle(4);

        nint = 0;
        win(1, 5, 0); win(1, 5, 0); win(1, 5, 0);
        idle(3);
        win(1, 9, 0); win(1, 9, 0); win(1, 9, 0);
        idle(2);
        chk("ovr_code", 32'(key_code), 5);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_nint", 32'(nint), 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("ack_valid", 32'(key_valid), 0);
        chk("ack_ov", 32'(overrun), 0);
        idle(4);

        nint = 0;
        win_conf(2, 7); win_conf(2, 7); win_conf(2, 7); win_conf(2, 7);
        idle(1);
        chk("conf_nint", 32'(nint), 0);
        win(1, 3, 0);
        cyc(1, 3, 0); cyc(0, 0, 0);
        do_reset(1);
        win(1, 3, 0);
        idle(4);
        chk("rst_nint", 32'(nint), 0);

        nint = 0;
        for (int w = 0; w < 54; w++)
            for (int c = 0; c < WIN; c++) cyc(1, 8, e_valid);
        idle(4);
        cyc(0, 0, 1);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("rep_nint", 32'(nint), 4);
`else
        chk("rep_nint", 32'(nint), 1);
`endif
        idle(4);

        for (int i = 0; i < 250; i++) begin
            int         k, n;
            logic [3:0] d;
            k = $urandom_range(0, 19);
            d = 4'($urandom_range(0, 3) * 3);
            n = $urandom_range(1, 5);
            if (k < 5) rwin(0, d);
            else if (k < 17) for (int j = 0; j < n; j++) rwin(1, d);
            else if (k < 19) rwin(2, d);
            else do_reset(1);
        end
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
